// File: rtl/lin_rx_pkg.sv
// Shared state encoding and constants for the LIN byte receiver.
package lin_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_BRK     = 3'd4,
    ST_WAIT_HI = 3'd5
  } lin_state_e;

  localparam int unsigned LIN_BREAK_BITS = 11;
  localparam int unsigned CNT_W          = 12;
  localparam int unsigned DOM_W          = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/lin_rx_sync.sv
// Two-flop synchronizer for the raw LIN line plus a falling-edge detector.
module lin_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_async_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/lin_rx.sv
// LIN byte receiver with sync-break detection.
// Optional LIN_RX_MAJORITY_EN: 2-of-3 majority sampling, decisions one cycle later.
module lin_rx
  import lin_rx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lin_rx_rtl,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_frame_err,
  output logic       rx_break,
  output logic       rx_busy
);

`ifdef LIN_RX_MAJORITY_EN
  localparam int unsigned SAMPLE_LAG = 1;
`else
  localparam int unsigned SAMPLE_LAG = 0;
`endif

  // Counter values are "cycles elapsed minus one" since the counter was cleared.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(BIT_CYCLES / 2 - 1 + SAMPLE_LAG);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [DOM_W-1:0] BRK_LEN    = DOM_W'(LIN_BREAK_BITS * BIT_CYCLES);

  logic rx_s, rx_fall, sample;

  lin_rx_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_async_i (lin_rx_rtl),
    .rx_s_o     (rx_s),
    .fall_o     (rx_fall)
  );

`ifdef LIN_RX_MAJORITY_EN
  logic hist1_q, hist2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= rx_s;
      hist2_q <= hist1_q;
    end
  end

  assign sample = maj3(rx_s, hist1_q, hist2_q);
`else
  assign sample = rx_s;
`endif

  lin_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DOM_W-1:0] dom_q, dom_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             brk_q, brk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dom_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    dom_d   = (dom_q == '1) ? dom_q : dom_q + DOM_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;

    if (!rx_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_fall) begin
            state_d = ST_START;
            cnt_d   = '0;
            dom_d   = DOM_W'(1);
          end
        end
        ST_START: begin
          if (cnt_q == START_LAST) begin
            state_d = sample ? ST_IDLE : ST_DATA;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            shift_d = {sample, shift_q[7:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            if (sample) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else if (shift_q != 8'h00) begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_HI;
            end else begin
              state_d = ST_BRK;
            end
          end
        end
        ST_BRK: begin
          if (rx_s) begin
            if (dom_q >= BRK_LEN) brk_d  = 1'b1;
            else                  ferr_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_HI: begin
          if (rx_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_break      = brk_q;
  assign rx_busy       = (state_q != ST_IDLE);

endmodule
